// File: rtl/fp_result_checker.sv
// In-order scoreboard behind fp_unit: queues expected results, compares each completion, sticky verdict.
// Define FP_CHECK_FLAGS_EN to store the expected flags and include them in the match.
module fp_result_checker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     exp_valid,
  input  logic [31:0]              exp_result,
  input  logic [4:0]               exp_flags,
  input  logic                     exp_nan_mask,
  output logic                     exp_ready,
  input  logic                     res_valid,
  input  logic [31:0]              res_result,
  input  logic [4:0]               res_flags,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [CNT_W-1:0]         pass_count,
  output logic                     fail,
  output logic                     underflow_err,
  output logic [31:0]              fail_ref_result,
  output logic [31:0]              fail_calc_result,
  output logic [31:0]              fail_result_diff,
  output logic [4:0]               fail_flags_diff
);

  // state | meaning
  // RUN   | comparing and counting passes
  // HALT  | mismatch or underflow seen; pops continue, verdict frozen
  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  state_e state_q, state_d;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [31:0]      mem_result_q [DEPTH];
  logic [31:0]      mem_result_d [DEPTH];
  logic [DEPTH-1:0] mem_nan_q, mem_nan_d;

  logic [CNT_W-1:0] pass_count_q, pass_count_d;
  logic             fail_q, fail_d;
  logic             underflow_err_q, underflow_err_d;
  logic [31:0]      fail_ref_q, fail_ref_d;
  logic [31:0]      fail_calc_q, fail_calc_d;
  logic [31:0]      fail_rdiff_q, fail_rdiff_d;

  logic [AW:0]   count;
  logic          full;
  logic          do_push, do_pop, empty_pop;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [31:0]   rdiff;
  logic [4:0]    fdiff;
  logic          match;
  logic          count_en, capture_en;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == (AW+1)'(DEPTH));
  assign wr_idx    = wr_ptr_q[AW-1:0];
  assign rd_idx    = rd_ptr_q[AW-1:0];
  // Clear wins over any push or pop in the same cycle.
  assign do_push   = exp_valid & ~full & ~clear;
  assign do_pop    = res_valid & (count != '0) & ~clear;
  assign empty_pop = res_valid & (count == '0) & ~clear;

  always_comb begin
    rdiff = mem_result_q[rd_idx] ^ res_result;
    // Canonical NaN may differ from the reference NaN in sign and payload.
    if (mem_nan_q[rd_idx] && (res_result == CANON_NAN)) begin
      rdiff = rdiff & 32'h7FC0_0000;
    end
  end

`ifdef FP_CHECK_FLAGS_EN
  logic [4:0] mem_flags_q [DEPTH];
  logic [4:0] mem_flags_d [DEPTH];
  logic [4:0] fail_fdiff_q, fail_fdiff_d;

  assign fdiff = mem_flags_q[rd_idx] ^ res_flags;

  always_comb begin
    mem_flags_d = mem_flags_q;
    if (do_push) mem_flags_d[wr_idx] = exp_flags;
    fail_fdiff_d = fail_fdiff_q;
    if (clear)           fail_fdiff_d = '0;
    else if (capture_en) fail_fdiff_d = fdiff;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_flags_q[i] <= '0;
      fail_fdiff_q <= '0;
    end else begin
      mem_flags_q  <= mem_flags_d;
      fail_fdiff_q <= fail_fdiff_d;
    end
  end

  assign fail_flags_diff = fail_fdiff_q;
`else
  logic unused_flags;
  assign unused_flags    = ^{exp_flags, res_flags};
  assign fdiff           = '0;
  assign fail_flags_diff = '0;
`endif

  assign match = (rdiff == '0) && (fdiff == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (clear)                     state_d = ST_RUN;
        else if (empty_pop)            state_d = ST_HALT;
        else if (do_pop && !match)     state_d = ST_HALT;
      end
      ST_HALT: begin
        if (clear) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    count_en   = 1'b0;
    capture_en = 1'b0;
    if (state_q == ST_RUN) begin
      count_en   = do_pop & match;
      capture_en = do_pop & ~match;
    end
  end

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    mem_result_d    = mem_result_q;
    mem_nan_d       = mem_nan_q;
    pass_count_d    = pass_count_q;
    fail_d          = fail_q;
    underflow_err_d = underflow_err_q;
    fail_ref_d      = fail_ref_q;
    fail_calc_d     = fail_calc_q;
    fail_rdiff_d    = fail_rdiff_q;
    if (clear) begin
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      pass_count_d    = '0;
      fail_d          = 1'b0;
      underflow_err_d = 1'b0;
      fail_ref_d      = '0;
      fail_calc_d     = '0;
      fail_rdiff_d    = '0;
    end else begin
      if (do_push) begin
        mem_result_d[wr_idx] = exp_result;
        mem_nan_d[wr_idx]    = exp_nan_mask;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (do_pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      if (empty_pop) underflow_err_d = 1'b1;
      if (count_en && (pass_count_q != '1)) pass_count_d = pass_count_q + 1'b1;
      if (capture_en) begin
        fail_d       = 1'b1;
        fail_ref_d   = mem_result_q[rd_idx];
        fail_calc_d  = res_result;
        fail_rdiff_d = rdiff;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      for (int i = 0; i < DEPTH; i++) mem_result_q[i] <= '0;
      mem_nan_q       <= '0;
      pass_count_q    <= '0;
      fail_q          <= 1'b0;
      underflow_err_q <= 1'b0;
      fail_ref_q      <= '0;
      fail_calc_q     <= '0;
      fail_rdiff_q    <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      mem_result_q    <= mem_result_d;
      mem_nan_q       <= mem_nan_d;
      pass_count_q    <= pass_count_d;
      fail_q          <= fail_d;
      underflow_err_q <= underflow_err_d;
      fail_ref_q      <= fail_ref_d;
      fail_calc_q     <= fail_calc_d;
      fail_rdiff_q    <= fail_rdiff_d;
    end
  end

  assign exp_ready        = ~full;
  assign pending          = count;
  assign pass_count       = pass_count_q;
  assign fail             = fail_q;
  assign underflow_err    = underflow_err_q;
  assign fail_ref_result  = fail_ref_q;
  assign fail_calc_result = fail_calc_q;
  assign fail_result_diff = fail_rdiff_q;

endmodule

// File: tb/tb_fp_result_checker.sv
// Bench for fp_result_checker: queue-based reference model plus directed boundary checks.
module tb_fp_result_checker;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_result = '0;
  logic [4:0]  exp_flags = '0;
  logic        exp_nan_mask = 1'b0;
  logic        exp_ready;
  logic        res_valid = 1'b0;
  logic [31:0] res_result = '0;
  logic [4:0]  res_flags = '0;
  logic        clear = 1'b0;
  logic [2:0]  pending;
  logic [31:0] pass_count;
  logic        fail;
  logic        underflow_err;
  logic [31:0] fail_ref_result, fail_calc_result, fail_result_diff;
  logic [4:0]  fail_flags_diff;

  fp_result_checker #(.DEPTH(4), .CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .exp_valid(exp_valid), .exp_result(exp_result), .exp_flags(exp_flags),
    .exp_nan_mask(exp_nan_mask), .exp_ready(exp_ready),
    .res_valid(res_valid), .res_result(res_result), .res_flags(res_flags),
    .clear(clear), .pending(pending), .pass_count(pass_count), .fail(fail),
    .underflow_err(underflow_err), .fail_ref_result(fail_ref_result),
    .fail_calc_result(fail_calc_result), .fail_result_diff(fail_result_diff),
    .fail_flags_diff(fail_flags_diff)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  f;
    logic        m;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] m_pass;
  logic        m_fail, m_uf, m_halt;
  logic [31:0] m_ref, m_calc, m_rdiff;
  logic [4:0]  m_fdiff;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_pass = '0; m_fail = 0; m_uf = 0; m_halt = 0;
    m_ref = '0; m_calc = '0; m_rdiff = '0; m_fdiff = '0;
  endtask

  task automatic model_step(input logic ev, input logic [31:0] er, input logic [4:0] ef,
                            input logic em, input logic rv, input logic [31:0] rr,
                            input logic [4:0] rf, input logic clr);
    ent_t        h, n;
    logic [31:0] rd;
    logic [4:0]  fd;
    bit          was_full;
    if (clr) begin
      model_reset();
      return;
    end
    was_full = (sb.size() == 4);
    if (rv) begin
      if (sb.size() == 0) begin
        m_uf = 1; m_halt = 1;
      end else begin
        h = sb.pop_front();
        rd = h.r ^ rr;
        if (h.m && rr == 32'h7FC00000) begin
          rd[31] = 1'b0;
          rd[21:0] = '0;
        end
`ifdef FP_CHECK_FLAGS_EN
        fd = h.f ^ rf;
`else
        fd = '0;
`endif
        if (!m_halt) begin
          if (rd == 0 && fd == 0) begin
            if (m_pass != 32'hFFFFFFFF) m_pass++;
          end else begin
            m_fail = 1; m_halt = 1;
            m_ref = h.r; m_calc = rr; m_rdiff = rd; m_fdiff = fd;
          end
        end
      end
    end
    if (ev && !was_full) begin
      n.r = er; n.f = ef; n.m = em;
      sb.push_back(n);
    end
  endtask

  task automatic check_all();
    chk("pending", 32'(pending), 32'(sb.size()));
    chk("exp_ready", 32'(exp_ready), 32'(sb.size() != 4));
    chk("pass_count", pass_count, m_pass);
    chk("fail", 32'(fail), 32'(m_fail));
    chk("underflow_err", 32'(underflow_err), 32'(m_uf));
    chk("fail_ref_result", fail_ref_result, m_ref);
    chk("fail_calc_result", fail_calc_result, m_calc);
    chk("fail_result_diff", fail_result_diff, m_rdiff);
    chk("fail_flags_diff", 32'(fail_flags_diff), 32'(m_fdiff));
  endtask

  task automatic step(input logic ev, input logic [31:0] er, input logic [4:0] ef,
                      input logic em, input logic rv, input logic [31:0] rr,
                      input logic [4:0] rf, input logic clr);
    @(negedge clock);
    exp_valid = ev; exp_result = er; exp_flags = ef; exp_nan_mask = em;
    res_valid = rv; res_result = rr; res_flags = rf; clear = clr;
    model_step(ev, er, ef, em, rv, rr, rf, clr);
    @(posedge clock);
    #1;
    exp_valid = 0; res_valid = 0; clear = 0;
    check_all();
  endtask

  task automatic push(input logic [31:0] r, input logic [4:0] f, input logic m);
    step(1, r, f, m, 0, '0, '0, 0);
  endtask

  task automatic pop(input logic [31:0] r, input logic [4:0] f);
    step(0, '0, '0, 0, 1, r, f, 0);
  endtask

  task automatic do_clear();
    step(0, '0, '0, 0, 0, '0, '0, 1);
  endtask

  task automatic drain();
    while (sb.size() > 0) pop(sb[0].r, sb[0].f);
  endtask

  initial begin
    logic        ev, rv, em;
    logic [31:0] er, rr;
    logic [4:0]  ef, rf;

    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    chk("rst_exp_ready", 32'(exp_ready), 32'd1);
    reset = 1'b1;

    push(32'h3F800000, 5'h00, 1);
    pop(32'h3F800000, 5'h00);
    chk("basic_pass", pass_count, 32'd1);

    push(32'h7FC00001, 5'h10, 1);
    pop(32'h7FC00000, 5'h10);
    chk("nan_relax_pass", pass_count, 32'd2);

    for (int i = 0; i < 40; i++) begin
      ev = 1'($urandom_range(0, 1));
      em = 1'($urandom_range(0, 1));
      ef = 5'($urandom_range(0, 31));
      er = $urandom;
      if (em && $urandom_range(0, 2) == 0) er[30:22] = 9'h1FF;
      rv = (sb.size() > 0) && ($urandom_range(0, 1) == 1);
      rr = '0; rf = '0;
      if (sb.size() > 0) begin
        rr = sb[0].r;
        rf = sb[0].f;
        if (sb[0].m && sb[0].r[30:22] == 9'h1FF) rr = 32'h7FC00000;
      end
      step(ev, er, ef, em, rv, rr, rf, 0);
    end
    drain();
    chk("random_no_fail", 32'(fail), 32'd0);

    push(32'h7FC00001, 5'h10, 0);
    pop(32'h7FC00000, 5'h10);
    chk("nomask_fail", 32'(fail), 32'd1);
    chk("nomask_diff", fail_result_diff, 32'h00000001);

    step(1, 32'h12345678, 5'h0, 0, 0, '0, '0, 1);
    chk("clear_pending", 32'(pending), 32'd0);
    chk("clear_fail", 32'(fail), 32'd0);

    for (int i = 0; i < 4; i++) push(32'h41000000 + i, 5'h0, 0);
    chk("full_ready", 32'(exp_ready), 32'd0);
    step(1, 32'hDEADBEEF, 5'h0, 0, 1, 32'h41000000, 5'h0, 0);
    chk("full_drop_pending", 32'(pending), 32'd3);
    drain();
    chk("full_no_fail", 32'(fail), 32'd0);

    do_clear();
    push(32'h40000000, 5'h01, 1);
    pop(32'h40000000, 5'h00);
    push(32'h3F000000, 5'h00, 0);
    pop(32'h3F000000, 5'h00);
`ifdef FP_CHECK_FLAGS_EN
    chk("flags_fail", 32'(fail), 32'd1);
    chk("flags_diff", 32'(fail_flags_diff), 32'h01);
    chk("flags_ref", fail_ref_result, 32'h40000000);
    chk("halt_no_count", pass_count, 32'd0);
`else
    chk("flags_ignored", 32'(fail), 32'd0);
    chk("flags_pass", pass_count, 32'd2);
`endif

    do_clear();
    step(1, 32'hAAAA5555, 5'h0, 0, 1, 32'h1, 5'h0, 0);
    chk("uf_err", 32'(underflow_err), 32'd1);
    chk("uf_pending", 32'(pending), 32'd1);
    chk("uf_pass", pass_count, 32'd0);
    pop(32'hAAAA5555, 5'h0);
    chk("uf_halt_no_count", pass_count, 32'd0);

    do_clear();
    push(32'h1, 5'h0, 0);
    pop(32'h1, 5'h0);
    for (int i = 0; i < 3; i++) push(32'h2 + i, 5'h0, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("midrst_pass", pass_count, 32'd0);
    chk("midrst_ready", 32'(exp_ready), 32'd1);
    @(negedge clock);
    reset = 1'b1;

    push(32'h5, 5'h0, 0);
    pop(32'h6, 5'h0);
    chk("halt_fail", 32'(fail), 32'd1);
    push(32'h7, 5'h0, 0);
    do_clear();
    chk("halt_clear_fail", 32'(fail), 32'd0);
    chk("halt_clear_pending", 32'(pending), 32'd0);
    push(32'h8, 5'h0, 0);
    pop(32'h8, 5'h0);
    chk("run_after_clear", pass_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_result_checker.md
Name: fp_result_checker

Overview:
- Synthesizable scoreboard placed directly downstream of fp_unit.
- Holds expected result/flags for each issued operation in an in-order FIFO.
- On each fp_unit completion it pops the head entry and compares it against the computed result/flags, with the canonical-NaN relaxation applied.
- Counts passes and freezes diagnostic state on the first mismatch, so regression benches and on-chip self-test can read a pass/fail verdict.

Parameters:
- DEPTH, 4, number of outstanding expected entries (power of two, >=2)
- CNT_W, 32, width of pass counter

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- exp_valid  in  1  push expected entry (same cycle op is issued to fp_unit)
- exp_result  in  32  expected result
- exp_flags  in  5  expected flags (NV,DZ,OF,UF,NX)
- exp_nan_mask  in  1  1 = float-result op, canonical-NaN relaxation allowed; 0 = fcmp/fcvt_f2i
- exp_ready  out  1  FIFO not full
- res_valid  in  1  fp_unit result valid (ready pulse)
- res_result  in  32  computed result
- res_flags  in  5  computed flags
- clear  in  1  synchronous clear of counters, sticky status and FIFO
- pending  out  clog2(DEPTH)+1  entries currently held
- pass_count  out  CNT_W  number of matching comparisons
- fail  out  1  sticky mismatch
- underflow_err  out  1  sticky: res_valid with empty FIFO
- fail_ref_result  out  32  head expected result at first mismatch
- fail_calc_result  out  32  computed result at first mismatch
- fail_result_diff  out  32  masked XOR at first mismatch
- fail_flags_diff  out  5  flags XOR at first mismatch

Behaviour:
- Reset (reset=0, async): all outputs 0 except exp_ready=1; FIFO empty; FSM=RUN.
- FIFO: circular, wr/rd pointers with wrap bit.
  - Push when exp_valid & exp_ready.
  - Pop when res_valid & pending!=0.
  - exp_ready depends only on registered state; a push at full is dropped even if a pop occurs in the same cycle.
  - Simultaneous push+pop with 0<pending<DEPTH: pending unchanged.
- Empty pop: res_valid with pending=0 sets underflow_err and the FSM goes to HALT. No compare is made. A push in the same cycle is still stored; it is never bypassed to the compare.
- Compare, combinational on the head entry:
  - rdiff = head.result ^ res_result; fdiff = head.flags ^ res_flags.
  - If head.nan_mask=1 and res_result==32'h7FC00000: rdiff[21:0]=0 and rdiff[31]=0.
  - Match iff rdiff==0 and fdiff==0.
- Latency: the compare is registered. pass_count, fail and the captured fields update on the clock edge ending the res_valid cycle and are visible the next cycle.
- FSM:
  - RUN: on match, pass_count++ (saturates at all-ones). On mismatch, capture the four fail_* fields, set fail, go to HALT.
  - HALT: pops continue so pending stays coherent. No counting, captured fields frozen.
  - HALT -> RUN only via clear or reset.
- clear: the next edge empties the FIFO, zeroes pending, pass_count, fail, underflow_err and fail_* fields, and sets FSM=RUN. clear has priority over a simultaneous push or pop.
- Reset mid-operation discards all entries; no partial-compare state survives.

Optional Feature:
- FP_CHECK_FLAGS_EN
- Defined: flags are stored in the FIFO and included in the match.
- Undefined: exp_flags is ignored, flag storage is not built, fdiff is forced to 0, and fail_flags_diff is tied to 0.

Test Plan:
- Push {0x3F800000, flags 0, mask 1}, then res_valid with 0x3F800000, flags 0 -> next cycle pass_count=1, fail=0, pending=0.
- Push {0x7FC00001, 0x10, mask 1}, result 0x7FC00000 flags 0x10 -> pass (NaN relaxation). Same with mask 0 -> fail=1, fail_result_diff=0x00000001.
- Push 4 entries (DEPTH=4): exp_ready=0. A 5th push with simultaneous res_valid -> 5th dropped, pending=3.
- Expected 0x40000000 flags 0x01, result 0x40000000 flags 0x00 -> fail=1, fail_flags_diff=0x01, fail_ref_result=0x40000000. A later matching result leaves pass_count unchanged. (Without FP_CHECK_FLAGS_EN: pass.)
- res_valid with pending=0 while exp_valid=1 -> underflow_err=1, pending=1, pass_count=0.
- Mid-run with 3 pending, assert reset -> all outputs 0, exp_ready=1. Alternatively pulse clear in HALT -> FSM RUN, fail=0, pending=0.
